// File: rtl/hcsr04_ctrl.sv
`timescale 1ns/1ps
// hcsr04_ctrl: HC-SR04 ranging sequencer (TRIG pulse, echo wait, minimum period).
// Optional macro HCSR04_AVG_EN: publish the truncated mean of every 4 accepted echoes.
module hcsr04_ctrl #(
    parameter int unsigned TRIG_TICKS   = 500,
    parameter int unsigned ARM_TIMEOUT  = 100000,
    parameter int unsigned PERIOD_TICKS = 3000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        continuous,
    output logic        trig,
    input  logic [20:0] meas_ticks,
    input  logic        meas_valid,
    input  logic        meas_timeout,
    input  logic        meas_busy,
    output logic [20:0] result_ticks,
    output logic        result_valid,
    output logic        result_err,
    output logic        ctrl_busy
);
    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_ARM, S_ECHO, S_HOLDOFF} state_t;

    // All phase timing is measured from the TRIG rising edge on one counter.
    localparam logic [21:0] C_TRIG_END = 22'(TRIG_TICKS - 1);
    localparam logic [21:0] C_ARM_END  = 22'(TRIG_TICKS + ARM_TIMEOUT - 1);
    localparam logic [21:0] C_PER_END  = 22'(PERIOD_TICKS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [21:0] r_per_cnt;
    logic        r_trig;
    logic        r_valid;
    logic        r_err;
    logic [20:0] r_ticks;
    logic        w_accept;
    logic        w_fail;
    logic        w_trig_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start || continuous) w_state_nxt = S_TRIG;
            S_TRIG:    if (r_per_cnt == C_TRIG_END) w_state_nxt = S_ARM;
            S_ARM: begin
                if (meas_valid)                   w_state_nxt = S_HOLDOFF;
                else if (meas_busy)               w_state_nxt = S_ECHO;
                else if (r_per_cnt == C_ARM_END)  w_state_nxt = S_HOLDOFF;
            end
            S_ECHO:    if (meas_valid || meas_timeout) w_state_nxt = S_HOLDOFF;
            S_HOLDOFF: if (r_per_cnt >= C_PER_END) w_state_nxt = continuous ? S_TRIG : S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_fail   = 1'b0;
        case (r_state)
            S_ARM: begin
                w_accept = meas_valid;
                w_fail   = !meas_valid && !meas_busy && (r_per_cnt == C_ARM_END);
            end
            S_ECHO: begin
                w_accept = meas_valid;
                w_fail   = !meas_valid && meas_timeout;
            end
            default: ;
        endcase
    end

    assign w_trig_start = (w_state_nxt == S_TRIG) && (r_state != S_TRIG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt <= '0;
            r_trig    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_trig <= (w_state_nxt == S_TRIG);
            r_err  <= w_fail;
            if (w_trig_start)
                r_per_cnt <= '0;
            else if ((r_state != S_IDLE) && (r_per_cnt != '1))
                r_per_cnt <= r_per_cnt + 22'd1;
        end
    end

`ifdef HCSR04_AVG_EN
    logic [22:0] r_acc;
    logic [1:0]  r_nsamp;
    logic [22:0] w_sum;

    assign w_sum = r_acc + {2'b00, meas_ticks};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_nsamp <= '0;
            r_ticks <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_fail) begin
                r_acc   <= '0;
                r_nsamp <= '0;
            end else if (w_accept) begin
                // Sample count wraps to zero on the fourth sample, restarting the window.
                r_nsamp <= r_nsamp + 2'd1;
                if (r_nsamp == 2'd3) begin
                    r_ticks <= w_sum[22:2];
                    r_valid <= 1'b1;
                    r_acc   <= '0;
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ticks <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) r_ticks <= meas_ticks;
        end
    end
`endif

    assign trig         = r_trig;
    assign result_ticks = r_ticks;
    assign result_valid = r_valid;
    assign result_err   = r_err;
    assign ctrl_busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_hcsr04_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for hcsr04_ctrl: table vectors, hand sequences and random echoes
// checked against an event-level model (strobe time relative to TRIG fall).
module tb_hcsr04_ctrl;
    localparam int TT = 5;
    localparam int AT = 20;
    localparam int PT = 100;
    localparam int K_VALID = 0, K_SHORT = 1, K_TMO = 2, K_NONE = 3;

    typedef struct {
        int d; int w; int kind; int v;
        bit exp_err; int exp_lat; int exp_ticks;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, start, continuous, trig;
    logic [20:0] meas_ticks, result_ticks;
    logic        meas_valid, meas_timeout, meas_busy;
    logic        result_valid, result_err, ctrl_busy;

    always #5 clk = ~clk;

    hcsr04_ctrl #(.TRIG_TICKS(TT), .ARM_TIMEOUT(AT), .PERIOD_TICKS(PT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .trig(trig),
        .meas_ticks(meas_ticks), .meas_valid(meas_valid), .meas_timeout(meas_timeout),
        .meas_busy(meas_busy), .result_ticks(result_ticks), .result_valid(result_valid),
        .result_err(result_err), .ctrl_busy(ctrl_busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int t = 0;
    int rise_q[$], fall_q[$], idle_q[$], err_q[$], val_t_q[$], val_v_q[$];
    int et[$], ev[$];
    logic prev_trig = 1'b0, prev_busy = 1'b0;
    int m_ticks, m_sum, m_n;
    vec_t tbl[9];
    int avg_in[4];
    int lat, dd, ww, vv, kk;
    bit e, p;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        t++;
        if (trig && !prev_trig) rise_q.push_back(t);
        if (!trig && prev_trig) fall_q.push_back(t);
        if (!ctrl_busy && prev_busy) idle_q.push_back(t);
        if (result_valid) begin val_t_q.push_back(t); val_v_q.push_back(int'(result_ticks)); end
        if (result_err) err_q.push_back(t);
        prev_trig = trig;
        prev_busy = ctrl_busy;
    endtask

    task automatic clear_q();
        rise_q.delete(); fall_q.delete(); idle_q.delete();
        err_q.delete(); val_t_q.delete(); val_v_q.delete();
    endtask

    // Reference: an echo first seen d cycles after TRIG fall is accepted only if d <= AT.
    task automatic predict(input int d, w, kind, v, output int olat, output bit oerr, output bit opub);
        if (kind == K_NONE || d > AT) begin olat = AT; oerr = 1'b1; end
        else if (kind == K_TMO)       begin olat = d + w; oerr = 1'b1; end
        else begin olat = (kind == K_SHORT) ? d : d + w; oerr = 1'b0; end
        opub = !oerr;
`ifdef HCSR04_AVG_EN
        if (oerr) begin m_sum = 0; m_n = 0; end
        else begin
            m_sum += v; m_n++;
            opub = (m_n == 4);
            if (opub) begin m_ticks = m_sum / 4; m_sum = 0; m_n = 0; end
        end
`else
        if (!oerr) m_ticks = v;
`endif
    endtask

    task automatic drive_echo(input int d, w, kind, v, input bit drop);
        for (int i = 1; i < d; i++) begin start = 1'($urandom_range(0, 1)); step(); end
        start = 1'b0;
        if (kind == K_VALID || kind == K_TMO) begin
            meas_busy = 1'b1;
            for (int i = 0; i < w; i++) begin
                if (drop && i == w / 2) continuous = 1'b0;
                start = 1'($urandom_range(0, 1));
                step();
            end
            start = 1'b0;
            meas_busy = 1'b0;
            if (kind == K_VALID) begin meas_valid = 1'b1; meas_ticks = 21'(v); end
            else meas_timeout = 1'b1;
            step();
            meas_valid = 1'b0;
            meas_timeout = 1'b0;
        end else if (kind == K_SHORT) begin
            meas_valid = 1'b1; meas_ticks = 21'(v);
            step();
            meas_valid = 1'b0;
        end
        meas_ticks = 21'($urandom);
    endtask

    task automatic one_meas(input string tag, input int d, w, kind, v,
                            input bit exp_err, exp_pub, input int exp_lat, exp_ticks);
        int f, g;
        clear_q();
        start = 1'b1;
        step();
        start = 1'b0;
        g = 0;
        while (fall_q.size() == 0 && g < TT + 10) begin step(); g++; end
        check({tag, " trig rises"}, rise_q.size(), 1);
        check({tag, " trig falls"}, fall_q.size(), 1);
        if (rise_q.size() == 0 || fall_q.size() == 0) return;
        f = fall_q[0];
        check({tag, " trig width"}, f - rise_q[0], TT);
        drive_echo(d, w, kind, v, 1'b0);
        g = 0;
        while (idle_q.size() == 0 && g < PT + 20) begin
            start = 1'($urandom_range(0, 1));
            step();
            g++;
        end
        start = 1'b0;
        check({tag, " idle after period"}, (idle_q.size() > 0) ? idle_q[0] - rise_q[0] : -1, PT);
        check({tag, " err strobes"}, err_q.size(), exp_err ? 1 : 0);
        check({tag, " valid strobes"}, val_t_q.size(), exp_pub ? 1 : 0);
        if (exp_err && err_q.size() > 0) check({tag, " err latency"}, err_q[0] - f, exp_lat);
        if (exp_pub && val_t_q.size() > 0) begin
            check({tag, " valid latency"}, val_t_q[0] - f, exp_lat);
            check({tag, " valid ticks"}, val_v_q[0], exp_ticks);
        end
        check({tag, " result_ticks"}, int'(result_ticks), exp_ticks);
    endtask

    task automatic run_pred(input string tag, input int d, w, kind, v);
        int l; bit er, pb;
        predict(d, w, kind, v, l, er, pb);
        one_meas(tag, d, w, kind, v, er, pb, l, m_ticks);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0;
        meas_ticks = '0; meas_valid = 1'b0; meas_timeout = 1'b0; meas_busy = 1'b0;
        m_ticks = 0; m_sum = 0; m_n = 0;
        repeat (3) step();
        check("reset trig", trig, 0);
        check("reset result_ticks", int'(result_ticks), 0);
        check("reset result_valid", result_valid, 0);
        check("reset result_err", result_err, 0);
        check("reset ctrl_busy", ctrl_busy, 0);
        rst_n = 1'b1;
        step();

`ifndef HCSR04_AVG_EN
        tbl[0] = '{3, 30, K_VALID, 1234, 1'b0, 33, 1234};
        tbl[1] = '{1, 1, K_VALID, 58000, 1'b0, 2, 58000};
        tbl[2] = '{20, 10, K_VALID, 2097151, 1'b0, 30, 2097151};
        tbl[3] = '{21, 10, K_VALID, 77, 1'b1, 20, 2097151};
        tbl[4] = '{6, 7, K_SHORT, 4321, 1'b0, 6, 4321};
        tbl[5] = '{5, 12, K_TMO, 999, 1'b1, 17, 4321};
        tbl[6] = '{1, 0, K_NONE, 5, 1'b1, 20, 4321};
        tbl[7] = '{20, 3, K_SHORT, 0, 1'b0, 20, 0};
        tbl[8] = '{2, 40, K_VALID, 321, 1'b0, 42, 321};
        for (int i = 0; i < 9; i++) begin
            one_meas($sformatf("vec%0d", i), tbl[i].d, tbl[i].w, tbl[i].kind, tbl[i].v,
                     tbl[i].exp_err, !tbl[i].exp_err, tbl[i].exp_lat, tbl[i].exp_ticks);
            m_ticks = tbl[i].exp_ticks;
        end
`else
        avg_in = '{1000, 1001, 1002, 1005};
        run_pred("avg clear", 1, 0, K_NONE, 0);
        for (int i = 0; i < 4; i++) run_pred($sformatf("avg%0d", i), 2, 3, K_VALID, avg_in[i]);
        check("avg mean", int'(result_ticks), 1002);
        run_pred("avg s0", 3, 4, K_VALID, 5000);
        run_pred("avg s1", 3, 4, K_SHORT, 6000);
        run_pred("avg err", 4, 5, K_TMO, 0);
        for (int i = 0; i < 4; i++) run_pred($sformatf("avg post%0d", i), 2, 5, K_VALID, 400 + 4 * i);
        check("avg after error", int'(result_ticks), 406);
`endif

        // Asynchronous reset in the middle of the TRIG pulse.
        clear_q();
        start = 1'b1; step(); start = 1'b0; step(); step();
        check("pre-reset trig high", trig, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset trig", trig, 0);
        check("async reset result_ticks", int'(result_ticks), 0);
        check("async reset ctrl_busy", ctrl_busy, 0);
        check("async reset result_valid", result_valid, 0);
        check("async reset result_err", result_err, 0);
        step();
        rst_n = 1'b1;
        m_ticks = 0; m_sum = 0; m_n = 0;
        prev_trig = 1'b0; prev_busy = 1'b0;
        step();
        run_pred("post-reset", 4, 6, K_VALID, 4242);

        // Continuous ranging, dropped in the middle of the third echo.
        clear_q(); et.delete(); ev.delete();
        continuous = 1'b1;
        for (int k = 0; k < 3; k++) begin
            kk = 0;
            while (fall_q.size() <= k && kk < PT + 20) begin step(); kk++; end
            if (fall_q.size() <= k) break;
            dd = $urandom_range(1, AT); ww = $urandom_range(2, 40); vv = $urandom_range(0, 2097151);
            predict(dd, ww, K_VALID, vv, lat, e, p);
            if (p) begin et.push_back(fall_q[k] + lat); ev.push_back(m_ticks); end
            drive_echo(dd, ww, K_VALID, vv, k == 2);
        end
        continuous = 1'b0;
        repeat (PT + 30) step();
        check("cont rise count", rise_q.size(), 3);
        for (int k = 1; k < 3; k++)
            if (rise_q.size() > k) check($sformatf("cont spacing%0d", k), rise_q[k] - rise_q[k-1], PT);
        check("cont idle", (idle_q.size() > 0 && rise_q.size() > 2) ? idle_q[0] - rise_q[2] : -1, PT);
        check("cont err strobes", err_q.size(), 0);
        check("cont valid strobes", val_t_q.size(), et.size());
        for (int i = 0; i < et.size() && i < val_t_q.size(); i++) begin
            check($sformatf("cont valid time%0d", i), val_t_q[i], et[i]);
            check($sformatf("cont valid ticks%0d", i), val_v_q[i], ev[i]);
        end

        for (int i = 0; i < 16; i++) begin
            kk = $urandom_range(0, 3);
            dd = $urandom_range(1, AT + 5);
            ww = $urandom_range(1, 40);
            vv = $urandom_range(0, 2097151);
            run_pred($sformatf("rand%0d", i), dd, ww, kk, vv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
